// File: rtl/wbi_pkg.sv
// Shared definitions for the Wishbone classic command-stream initiator.
// Optional bus-timeout support is enabled with the WBI_TIMEOUT_EN macro.
package wbi_pkg;

    localparam int unsigned WB_DW              = 32;
    localparam int unsigned WB_AW              = 32;
    localparam logic [31:0] ADDR_INC           = 32'd4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbi_state_e;

endpackage

// File: rtl/wbi_timeout_cnt.sv
// Watchdog for an unanswered Wishbone strobe. Counts enabled cycles since the
// last clear and flags expiry in the cycle that would bring the count to
// MAX_CYCLES, so the owner can terminate on that same edge.
module wbi_timeout_cnt #(
    parameter int unsigned MAX_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Count unanswered bus cycles; cleared whenever the owner is outside BUS.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == CW'(MAX_CYCLES - 1));

endmodule

// File: rtl/wb_initiator_seq.sv
// Wishbone B4 classic initiator: turns one command (single access, read burst
// or write fill) into a sequence of separate single-beat CYCs, with a
// single-entry response channel that back-pressures the bus.
// Define WBI_TIMEOUT_EN to force an error after TIMEOUT_CYCLES unanswered STB
// cycles; otherwise the bus waits indefinitely for ack/err.
module wb_initiator_seq
    import wbi_pkg::*;
#(
    parameter int unsigned LEN_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_last_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic [WB_DW-1:0] wbm_dat_i,
    output logic             busy_o
);

    wbi_state_e       r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_cyc;
    logic             r_we;
    logic [WB_AW-1:0] r_adr;
    logic [WB_DW-1:0] r_dat;
    logic [3:0]       r_sel;
    logic             r_rsp_valid;
    logic [WB_DW-1:0] r_rsp_dat;
    logic             r_rsp_err;
    logic             r_rsp_last;

    logic w_in_bus;
    logic w_tmo;
    logic w_err;
    logic w_term;
    logic w_rd_ok;

    assign w_in_bus = (r_state == BUS) && r_cyc;

`ifdef WBI_TIMEOUT_EN
    logic w_tmo_en;

    assign w_tmo_en = w_in_bus && !wbm_ack_i && !wbm_err_i;

    wbi_timeout_cnt #(
        .MAX_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_clr    (r_state != BUS),
        .i_en     (w_tmo_en),
        .o_expired(w_tmo)
    );
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_tmo        = 1'b0;
`endif

    // err dominates ack; a timeout is reported exactly like a slave err.
    assign w_err   = wbm_err_i || w_tmo;
    assign w_term  = w_in_bus && (wbm_ack_i || w_err);
    assign w_rd_ok = !r_we && wbm_ack_i && !w_err;

    // Command accept, per-beat bus cycle, response hold and burst sequencing.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_dat   <= cmd_dat_i;
                        r_sel   <= cmd_sel_i;
                        r_rem   <= cmd_len_i;
                        r_cyc   <= 1'b1;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    if (w_term) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= w_rd_ok ? wbm_dat_i : '0;
                        r_rsp_err   <= w_err;
                        r_rsp_last  <= (r_rem == '0) || w_err;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_rem   <= r_rem - LEN_W'(1);
                            r_adr   <= r_adr + ADDR_INC;
                            r_cyc   <= 1'b1;
                            r_state <= BUS;
                        end
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_last_o  = r_rsp_last;

endmodule

// File: doc/wb_initiator_seq.md
Name: wb_initiator_seq

Overview:
- Wishbone classic (B4, non-pipelined) initiator that turns a command stream into bus cycles.
- It is the master-side counterpart of the user-area slave port.
- Lets internal controllers (LED pattern sequencer, LA-driven debug) read and write internal Wishbone slaves, e.g. LED frame RAM and PWM registers.
- Supports single accesses and short incrementing bursts: read burst, or write fill of the same word.

Parameters:
- LEN_W, 4, width of burst-length field; beats = cmd_len_i+1, so 1..16.
- TIMEOUT_CYCLES, 255, cycles of unanswered STB before forced error; used only with WBI_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1 = write (fill), 0 = read.
- cmd_adr_i  in  32  start byte address; bits [1:0] passed through unchanged.
- cmd_dat_i  in  32  write data, same word for every beat.
- cmd_sel_i  in  4  byte selects, same for every beat.
- cmd_len_i  in  LEN_W  beats minus one.
- rsp_valid_o  out  1  one response per beat.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_dat_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  beat terminated by ERR, or by timeout.
- rsp_last_o  out  1  final response of the command.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone control.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_ack_i, wbm_err_i  in  1 each  slave termination.
- wbm_dat_i  in  32  slave read data.
- busy_o  out  1  state != IDLE.

Behaviour:
- All outputs are registered except cmd_ready_o = (state==IDLE) and busy_o.
- Reset values: cyc/stb/we = 0, adr/dat/sel = 0, rsp_valid/err/last = 0, rsp_dat = 0, state IDLE.
- States: IDLE, BUS, RESP.
- IDLE -> BUS on cmd handshake at edge N:
  - latch we/adr/dat/sel and remaining = cmd_len_i;
  - cyc = stb = 1 from edge N, so the bus is visible in cycle N+1.
- BUS: hold cyc/stb/adr/dat/sel/we stable until ack or err is sampled high.
  - At that edge: cyc = stb = 0, rsp_valid = 1.
  - rsp_dat = wbm_dat_i for a read with ack, else 0.
  - rsp_err = err.
  - rsp_last = (remaining==0) | err.
  - Next state RESP.
  - Minimum latency: command handshake at edge N, combinational ack in N+1, rsp_valid high in cycle N+2.
- ack and err high together: treated as err.
- ack/err while stb=0: ignored.
- RESP: hold the response until rsp_ready_i; then rsp_valid = 0.
  - If rsp_last: go to IDLE.
  - Else: remaining -= 1, adr += 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), reassert cyc/stb, go to BUS.
  - Each beat is therefore a separate CYC.
- Error aborts the burst; no further beats are issued.
- The response channel is a single entry; no new beat starts until the previous response is consumed (back-pressure stalls the bus).
- Reset mid-operation: at the first reset edge cyc/stb drop, any pending response is discarded, state goes to IDLE.
- No retry and no RTY support.

Optional Feature:
- Macro WBI_TIMEOUT_EN.
- Defined:
  - counter cleared on entry to BUS, increments each BUS cycle without ack/err;
  - when it reaches TIMEOUT_CYCLES: terminate as err (cyc/stb drop, rsp_err = 1, rsp_last = 1, rsp_dat = 0).
- Undefined: no counter; BUS waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package wbi_pkg:
  - state enum (IDLE/BUS/RESP);
  - ADDR_INC = 4;
  - default TIMEOUT_CYCLES;
  - WB_DW = 32, WB_AW = 32.
- One sub-module wbi_timeout_cnt (clear/enable/expired), instantiated only under WBI_TIMEOUT_EN.

Test Plan:
- Single write: adr 0x3000_0010, dat 0xA5A5_0001, sel 0xF, len 0; slave acks in the first STB cycle -> one CYC with we = 1, response err = 0, last = 1, dat = 0, rsp_valid at N+2.
- Read burst: adr 0x3000_0000, len 3; slave returns adr^0xFFFF_FFFF with 2 wait states.
  - Expect 4 CYCs at 0x..00/04/08/0C, with CYC low between beats.
  - Expect 4 responses carrying matching data; last only on the 4th.
- Back-pressure: same burst with rsp_ready low for 5 cycles after each beat -> response held stable, next STB not issued until the handshake; order preserved.
- Error abort: len 7, slave asserts err on the 3rd beat (ack also high) -> 3 responses, the 3rd with err = 1, last = 1, dat = 0; no 4th CYC; returns to IDLE.
- Address wrap: adr 0xFFFF_FFFC, len 1 -> second beat at 0x0000_0000.
- Timeout/reset:
  - With WBI_TIMEOUT_EN and TIMEOUT_CYCLES = 8, a non-responding slave -> CYC drops after 8 STB cycles with err = 1, last = 1.
  - A separate run asserts wb_rst_i mid-BUS -> cyc/stb = 0 and rsp_valid = 0 on the next edge, cmd_ready = 1 after reset release.
